// File: rtl/mdu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// 4-bit MDU op codes and the IDLE/RUN/FIX state encoding.
package mdu_pkg;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;
  localparam logic [3:0] MSUBU = 4'd12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } mdu_state_e;

endpackage

// File: rtl/mdu_iter_core.sv
// Iterative arithmetic engine: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one bit per cycle, followed by a sign
// fix-up cycle. The full 2*WIDTH result is presented while done is high.
module mdu_iter_core
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 is_div,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   res
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  mdu_state_e state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;
  logic               div_q, div_d;
  logic               neg_q, neg_d;
  logic               sa_q, sa_d;

  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [WIDTH:0]     mul_upper;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff, div_rem;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_next, div_next;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

  // Operand magnitudes plus one shift-add and one shift-subtract step.
  // The low half of prod_q holds the multiplier (mult) or the dividend
  // being shifted out while quotient bits shift in (div).
  always_comb begin
    a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
    b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;
    mul_upper = {1'b0, prod_q[2*WIDTH-1:WIDTH]}
              + (prod_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    mul_next  = {mul_upper, prod_q[WIDTH-1:1]};
    div_shift = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opb_q});
    div_diff  = div_shift[WIDTH-1:0] - opb_q;
    div_rem   = div_ge ? div_diff : div_shift[WIDTH-1:0];
    div_next  = {div_rem, prod_q[WIDTH-2:0], div_ge};
  end

  // Next-state logic: latch operands on start, iterate WIDTH times, fix up.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opb_d   = opb_q;
    div_d   = div_q;
    neg_d   = neg_q;
    sa_d    = sa_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          prod_d  = {{WIDTH{1'b0}}, a_abs};
          opb_d   = b_abs;
          div_d   = is_div;
          neg_d   = is_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
          sa_d    = is_signed && a[WIDTH-1];
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        prod_d = div_q ? div_next : mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == LAST_ITER) begin
          state_d = FIX;
        end
      end
      FIX: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset abandons any op in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      sa_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opb_q   <= opb_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      sa_q    <= sa_d;
    end
  end

  // Sign fix-up: quotient/product negate on sA^sB, remainder follows A.
  always_comb begin
    quo_fix = neg_q ? -prod_q[WIDTH-1:0] : prod_q[WIDTH-1:0];
    rem_fix = sa_q ? -prod_q[2*WIDTH-1:WIDTH] : prod_q[2*WIDTH-1:WIDTH];
    res     = div_q ? {rem_fix, quo_fix} : (neg_q ? -prod_q : prod_q);
    busy    = (state_q != IDLE);
    done    = (state_q == FIX);
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MDU for the EX stage: op decode, Req gating, HI/LO registers,
// mthi/mtlo, mfhi/mflo read mux and completion pulse.
// Optional feature macro: MDU_MADD_EN enables MADD/MADDU/MSUB/MSUBU, which
// accumulate the product into {HI,LO}; without it those codes act as NOP.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic             Start,
  input  logic [3:0]       MDU_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] out,
  output logic             Busy,
  output logic             Done
);

  logic               arith_op, div_op, signed_op;
  logic               start_go;
  logic               core_busy, core_done;
  logic [2*WIDTH-1:0] core_res, hilo_res;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;
`ifdef MDU_MADD_EN
  logic               acc_op, sub_op;
  logic               acc_q, acc_d, sub_q, sub_d;
`endif

  // Decode the op code into the arithmetic class handed to the core.
  always_comb begin
    arith_op  = 1'b0;
    div_op    = 1'b0;
    signed_op = 1'b0;
`ifdef MDU_MADD_EN
    acc_op    = 1'b0;
    sub_op    = 1'b0;
`endif
    case (MDU_op)
      MULT:  begin arith_op = 1'b1; signed_op = 1'b1; end
      MULTU: begin arith_op = 1'b1; end
      DIV:   begin arith_op = 1'b1; signed_op = 1'b1; div_op = 1'b1; end
      DIVU:  begin arith_op = 1'b1; div_op = 1'b1; end
`ifdef MDU_MADD_EN
      MADD:  begin arith_op = 1'b1; signed_op = 1'b1; acc_op = 1'b1; end
      MADDU: begin arith_op = 1'b1; acc_op = 1'b1; end
      MSUB:  begin arith_op = 1'b1; signed_op = 1'b1; acc_op = 1'b1; sub_op = 1'b1; end
      MSUBU: begin arith_op = 1'b1; acc_op = 1'b1; sub_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign start_go = Start && !Req && arith_op && !core_busy;

  mdu_iter_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .clk       (clk),
    .reset     (reset),
    .start     (start_go),
    .is_div    (div_op),
    .is_signed (signed_op),
    .a         (A),
    .b         (B),
    .busy      (core_busy),
    .done      (core_done),
    .res       (core_res)
  );

  // Value written into {HI,LO} at completion: plain result or accumulation.
  always_comb begin
    hilo_res = core_res;
`ifdef MDU_MADD_EN
    if (acc_q) begin
      hilo_res = sub_q ? ({hi_q, lo_q} - core_res) : ({hi_q, lo_q} + core_res);
    end
`endif
  end

  // HI/LO update: completion write wins; mthi/mtlo only when idle and unflushed.
  always_comb begin
    hi_d   = hi_q;
    lo_d   = lo_q;
    done_d = 1'b0;
`ifdef MDU_MADD_EN
    acc_d  = acc_q;
    sub_d  = sub_q;
    if (start_go) begin
      acc_d = acc_op;
      sub_d = sub_op;
    end
`endif
    if (core_done) begin
      {hi_d, lo_d} = hilo_res;
      done_d       = 1'b1;
    end else if (!core_busy && !Req) begin
      if (MDU_op == MTHI) hi_d = A;
      if (MDU_op == MTLO) lo_d = A;
    end
  end

  // Architectural HI/LO and the one-cycle completion pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      hi_q   <= '0;
      lo_q   <= '0;
      done_q <= 1'b0;
`ifdef MDU_MADD_EN
      acc_q  <= 1'b0;
      sub_q  <= 1'b0;
`endif
    end else begin
      hi_q   <= hi_d;
      lo_q   <= lo_d;
      done_q <= done_d;
`ifdef MDU_MADD_EN
      acc_q  <= acc_d;
      sub_q  <= sub_d;
`endif
    end
  end

  // mfhi/mflo read port, deliberately not qualified by Busy.
  always_comb begin
    out = '0;
    if (MDU_op == MFHI) out = hi_q;
    else if (MDU_op == MFLO) out = lo_q;
  end

  assign HI   = hi_q;
  assign LO   = lo_q;
  assign Busy = core_busy;
  assign Done = done_q;

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter at WIDTH=32: directed vector table,
// hand-written multi-cycle sequences and randomized ops against an
// arithmetic reference model. Build with MDU_MADD_EN to cover accumulate ops.
module tb_mdu_iter;
  import mdu_pkg::*;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         Req;
  logic         Start;
  logic [3:0]   MDU_op;
  logic [W-1:0] A, B;
  logic [W-1:0] HI, LO, out;
  logic         Busy, Done;

  int vectors     = 0;
  int miscompares = 0;
  logic [63:0] modelHiLo = 64'd0;

  always #5 clk = ~clk;

  mdu_iter #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .Req    (Req),
    .Start  (Start),
    .MDU_op (MDU_op),
    .A      (A),
    .B      (B),
    .HI     (HI),
    .LO     (LO),
    .out    (out),
    .Busy   (Busy),
    .Done   (Done)
  );

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] expHi;
    logic [31:0] expLo;
  } vec_t;

  vec_t vecs[12];

  // Reference: plain 64-bit arithmetic on the architectural operands.
  function automatic logic [63:0] refModel(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [63:0] acc);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     q, m, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = acc;
    case (op)
      MULT:  r = sa * sb;
      MULTU: r = ua * ub;
      DIV: begin
        if (b == 32'd0) r = {a, (sa < 0) ? 32'd1 : 32'hFFFFFFFF};
        else begin q = sa / sb; m = sa % sb; r = {m[31:0], q[31:0]}; end
      end
      DIVU: begin
        if (b == 32'd0) r = {a, 32'hFFFFFFFF};
        else begin q = ua / ub; m = ua % ub; r = {m[31:0], q[31:0]}; end
      end
      MADD:  r = acc + 64'(sa * sb);
      MADDU: r = acc + 64'(ua * ub);
      MSUB:  r = acc - 64'(sa * sb);
      MSUBU: r = acc - 64'(ua * ub);
      default: r = acc;
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                               input logic start, input logic req);
    @(negedge clk);
    MDU_op = op;
    A      = a;
    B      = b;
    Start  = start;
    Req    = req;
  endtask

  // Issue one op and count the cycles Busy stays high (bounded).
  task automatic runOp(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int cycles);
    applyStimulus(op, a, b, 1'b1, 1'b0);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    cycles = 0;
    while (Busy && cycles <= 200) begin
      cycles++;
      tick();
    end
  endtask

  task automatic waitIdle(input string name);
    int n;
    n = 0;
    while (Busy && n <= 200) begin
      n++;
      tick();
    end
    checkOutput(name, {63'd0, Busy}, 64'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish, busy=%b", Busy);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          cycles;
    logic [3:0]  op;
    logic [31:0] ra, rb;
    logic [63:0] exp;

    vecs[0]  = '{"mult_neg3x7",   MULT,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB};
    vecs[1]  = '{"multu_max",     MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[2]  = '{"div_neg7_2",    DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{"divu_7_0",      DIVU,  32'd7,        32'd0,        32'd7,        32'hFFFFFFFF};
    vecs[4]  = '{"div_min_m1",    DIV,   32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000};
    vecs[5]  = '{"div_neg8_0",    DIV,   32'hFFFFFFF8, 32'd0,        32'hFFFFFFF8, 32'd1};
    vecs[6]  = '{"div_5_0",       DIV,   32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
    vecs[7]  = '{"div_7_neg2",    DIV,   32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
    vecs[8]  = '{"multu_2p16sq",  MULTU, 32'h00010000, 32'h00010000, 32'd1,        32'd0};
    vecs[9]  = '{"mult_min_sq",   MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'd0};
    vecs[10] = '{"divu_max_16",   DIVU,  32'hFFFFFFFF, 32'd16,       32'd15,       32'h0FFFFFFF};
    vecs[11] = '{"mult_0_m1",     MULT,  32'd0,        32'hFFFFFFFF, 32'd0,        32'd0};

    reset = 1'b0; Req = 1'b0; Start = 1'b0; MDU_op = NOP; A = '0; B = '0;
    tick(); tick();
    checkOutput("reset_hi",   {32'd0, HI}, 64'd0);
    checkOutput("reset_lo",   {32'd0, LO}, 64'd0);
    checkOutput("reset_busy", {63'd0, Busy}, 64'd0);
    checkOutput("reset_done", {63'd0, Done}, 64'd0);
    @(negedge clk); reset = 1'b1;

    // Directed table
    for (int i = 0; i < 12; i++) begin
      runOp(vecs[i].op, vecs[i].a, vecs[i].b, cycles);
      checkOutput({vecs[i].name, "_busy_cycles"}, 64'(cycles), 64'd33);
      checkOutput({vecs[i].name, "_done"}, {63'd0, Done}, 64'd1);
      checkOutput({vecs[i].name, "_hi"}, {32'd0, HI}, {32'd0, vecs[i].expHi});
      checkOutput({vecs[i].name, "_lo"}, {32'd0, LO}, {32'd0, vecs[i].expLo});
      modelHiLo = {vecs[i].expHi, vecs[i].expLo};
    end
    tick();
    checkOutput("done_one_cycle", {63'd0, Done}, 64'd0);

    // Start and mthi while busy are ignored
    applyStimulus(DIV, 32'd100, 32'd7, 1'b1, 1'b0);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (3) tick();
    applyStimulus(MULTU, 32'd5, 32'd5, 1'b1, 1'b0);
    tick();
    applyStimulus(MTHI, 32'h1234, 32'd0, 1'b0, 1'b0);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    waitIdle("busy_ignore_timeout");
    checkOutput("busy_ignore_hilo", {HI, LO}, {32'd2, 32'd14});
    modelHiLo = {32'd2, 32'd14};

    // Req gating of Start and mtlo, then plain mthi/mtlo
    applyStimulus(MULT, 32'd3, 32'd3, 1'b1, 1'b1);
    tick();
    checkOutput("start_req_busy", {63'd0, Busy}, 64'd0);
    applyStimulus(MTLO, 32'hDEAD, 32'd0, 1'b0, 1'b1);
    tick();
    checkOutput("mtlo_req_lo", {32'd0, LO}, 64'd14);
    applyStimulus(NOP, 32'd0, 32'd0, 1'b1, 1'b0);
    tick();
    checkOutput("start_nop_busy", {63'd0, Busy}, 64'd0);
    applyStimulus(MTLO, 32'hCAFE, 32'd0, 1'b0, 1'b0);
    tick();
    checkOutput("mtlo_lo", {32'd0, LO}, 64'hCAFE);
    applyStimulus(MTHI, 32'hBEEF, 32'd0, 1'b0, 1'b0);
    tick();
    checkOutput("mthi_hi", {32'd0, HI}, 64'hBEEF);
    modelHiLo = {32'hBEEF, 32'hCAFE};
    applyStimulus(MFHI, 32'd0, 32'd0, 1'b0, 1'b0);
    #1 checkOutput("out_mfhi", {32'd0, out}, 64'hBEEF);
    applyStimulus(MFLO, 32'd0, 32'd0, 1'b0, 1'b0);
    #1 checkOutput("out_mflo", {32'd0, out}, 64'hCAFE);
    applyStimulus(MTHI, 32'd0, 32'd0, 1'b0, 1'b1);
    #1 checkOutput("out_other", {32'd0, out}, 64'd0);
    tick();

`ifndef MDU_MADD_EN
    applyStimulus(MADD, 32'd3, 32'd4, 1'b1, 1'b0);
    tick();
    checkOutput("madd_disabled_busy", {63'd0, Busy}, 64'd0);
    applyStimulus(MSUBU, 32'd3, 32'd4, 1'b1, 1'b0);
    tick();
    checkOutput("msubu_disabled_busy", {63'd0, Busy}, 64'd0);
    checkOutput("madd_disabled_hilo", {HI, LO}, modelHiLo);
`else
    applyStimulus(MTHI, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    applyStimulus(MTLO, 32'd5, 32'd0, 1'b0, 1'b0); tick();
    runOp(MADD, 32'd3, 32'd4, cycles);
    checkOutput("madd_cycles", 64'(cycles), 64'd33);
    checkOutput("madd_hilo", {HI, LO}, {32'd0, 32'd17});
    applyStimulus(MTLO, 32'd0, 32'd0, 1'b0, 1'b0); tick();
    runOp(MSUB, 32'd1, 32'd1, cycles);
    checkOutput("msub_hilo", {HI, LO}, 64'hFFFFFFFF_FFFFFFFF);
    modelHiLo = {HI === 32'hFFFFFFFF ? 32'hFFFFFFFF : 32'hFFFFFFFF, 32'hFFFFFFFF};
`endif

    // Reset in the middle of a divide
    applyStimulus(DIV, 32'd100, 32'd3, 1'b1, 1'b0);
    tick();
    applyStimulus(NOP, 32'd0, 32'd0, 1'b0, 1'b0);
    repeat (9) tick();
    @(negedge clk); reset = 1'b0;
    tick();
    checkOutput("midreset_busy", {63'd0, Busy}, 64'd0);
    checkOutput("midreset_hilo", {HI, LO}, 64'd0);
    @(negedge clk); reset = 1'b1;
    tick();
    checkOutput("midreset_stays_idle", {63'd0, Busy}, 64'd0);
    modelHiLo = 64'd0;
    runOp(MULTU, 32'd6, 32'd7, cycles);
    checkOutput("post_reset_cycles", 64'(cycles), 64'd33);
    checkOutput("post_reset_hilo", {HI, LO}, 64'd42);
    modelHiLo = 64'd42;

    // Randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
`ifdef MDU_MADD_EN
      op = 4'($urandom_range(0, 7));
      op = (op < 4) ? op + 4'd1 : op + 4'd5;
`else
      op = 4'($urandom_range(1, 4));
`endif
      ra = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = 32'($urandom_range(0, 15));
        2: rb = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFFFFFF;
        default: rb = $urandom >> $urandom_range(0, 31);
      endcase
      exp = refModel(op, ra, rb, modelHiLo);
      runOp(op, ra, rb, cycles);
      checkOutput($sformatf("rand%0d_op%0d_cycles", i, op), 64'(cycles), 64'd33);
      checkOutput($sformatf("rand%0d_op%0d_%h_%h", i, op, ra, rb), {HI, LO}, exp);
      modelHiLo = exp;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
